uart_rx_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle data-valid strobe and holds it in a synchronous FIFO. A consumer (CPU bus bridge or command parser) drains the FIFO through a valid/ready handshake. The block also reports fill level, full/empty, a threshold flag and a sticky overrun error, so no byte is lost silently between the 16x-oversampled receiver and a slower consumer.

---
 rtl/uart_rx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer between a UART receiver and a
// slower consumer. Bytes offered on the receiver's one-cycle valid strobe are
// stored in a DEPTH-entry synchronous FIFO and drained with a show-ahead
// valid/ready handshake.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_wr_data/valid    byte and strobe from the receiver
//   o_rd_data/valid    head byte (0 while empty) and non-empty flag
//   i_rd_ready         consumer accepts head byte (pop = valid & ready)
//   o_level            stored byte count 0..DEPTH
//   o_empty/full       level == 0 / level == DEPTH
//   o_thresh           level >= THRESH
//   o_overrun          sticky: a byte was dropped while full
//   i_clr_overrun      one-cycle clear of o_overrun (a same-cycle drop wins)
//   o_drop_count       only with UART_RX_FIFO_DROP_CNT_EN defined: saturating
//                      count of dropped bytes, also cleared by i_clr_overrun
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_level,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_thresh,
  output logic              o_overrun,
`ifdef UART_RX_FIFO_DROP_CNT_EN
  output logic [7:0]        o_drop_count,
`endif
  input  logic              i_clr_overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_L = (ADDR_W + 1)'(THRESH);
  localparam logic [ADDR_W:0] ONE_L    = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              overrun;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // Status decode and handshake qualification from the level register.
  always_comb begin
    empty = (level == '0);
    full  = (level == DEPTH_L);
    pop   = !empty & i_rd_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push  = i_wr_valid & (!full | pop);
    drop  = i_wr_valid & full & !pop;
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (push && !i_rst) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and level counter; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + ONE_L;
        2'b01:   level <= level - ONE_L;
        default: level <= level;
      endcase
    end
  end

  // Sticky overrun flag; a drop in the clearing cycle keeps it set.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_count;

  // Saturating dropped-byte counter; drop together with clear yields 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      drop_count <= 8'd0;
    end else if (drop) begin
      if (i_clr_overrun) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (i_clr_overrun) begin
      drop_count <= 8'd0;
    end
  end

  assign o_drop_count = drop_count;
`endif

  // Show-ahead head byte, forced to zero while empty.
  always_comb begin
    if (empty) begin
      o_rd_data = '0;
    end else begin
      o_rd_data = mem[rd_ptr];
    end
  end

  assign o_rd_valid = !empty;
  assign o_level    = level;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_thresh   = (level >= THRESH_L);
  assign o_overrun  = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a directed vector table with constant expectations
// followed by randomized traffic, all steps also compared against a queue
// based reference model.
module tb_uart_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_wr_data = 8'h00;
  logic       i_wr_valid = 1'b0;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic       i_rd_ready = 1'b0;
  logic [4:0] o_level;
  logic       o_empty;
  logic       o_full;
  logic       o_thresh;
  logic       o_overrun;
  logic       i_clr_overrun = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] o_drop_count;
`endif

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DATA_W(8), .ADDR_W(4), .THRESH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_level(o_level), .o_empty(o_empty), .o_full(o_full),
    .o_thresh(o_thresh), .o_overrun(o_overrun),
`ifdef UART_RX_FIFO_DROP_CNT_EN
    .o_drop_count(o_drop_count),
`endif
    .i_clr_overrun(i_clr_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: plain queue of bytes plus flag and counter.
  logic [7:0] q[$];
  logic       m_ov = 1'b0;
  int         m_dc = 0;

  typedef struct {
    logic       rst;
    logic       wv;
    logic [7:0] wd;
    logic       rd;
    logic       clr;
    int         lvl;
    logic       rv;
    logic [7:0] rdat;
    logic       ov;
    logic       full;
    logic       thr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic wv, input logic [7:0] wd,
                              input logic rd, input logic clr);
    bit was_full, do_pop, do_drop;
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_dc = 0;
    end else begin
      was_full = (q.size() == 16);
      do_pop   = (q.size() > 0) && rd;
      do_drop  = wv && was_full && !do_pop;
      if (do_pop) void'(q.pop_front());
      if (wv && !do_drop) q.push_back(wd);
      if (do_drop) begin
        m_ov = 1'b1;
        m_dc = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
      end else if (clr) begin
        m_ov = 1'b0;
        m_dc = 0;
      end
    end
  endtask

  task automatic model_check();
    int n;
    n = q.size();
    chk("mdl_level",  32'(o_level), 32'(n));
    chk("mdl_valid",  32'(o_rd_valid), 32'(n > 0));
    chk("mdl_data",   32'(o_rd_data), (n > 0) ? 32'(q[0]) : 32'h0);
    chk("mdl_empty",  32'(o_empty), 32'(n == 0));
    chk("mdl_full",   32'(o_full), 32'(n == 16));
    chk("mdl_thresh", 32'(o_thresh), 32'(n >= 8));
    chk("mdl_ovr",    32'(o_overrun), 32'(m_ov));
`ifdef UART_RX_FIFO_DROP_CNT_EN
    chk("mdl_dropcnt", 32'(o_drop_count), 32'(m_dc));
`endif
  endtask

  // Drive inputs at negedge, let one rising edge pass, then compare.
  task automatic step(input logic rst, input logic wv, input logic [7:0] wd,
                      input logic rd, input logic clr);
    @(negedge i_clk);
    i_rst = rst; i_wr_valid = wv; i_wr_data = wd; i_rd_ready = rd; i_clr_overrun = clr;
    @(posedge i_clk);
    model_update(rst, wv, wd, rd, clr);
    #1;
    model_check();
  endtask

  task automatic add(input logic rst, input logic wv, input logic [7:0] wd,
                     input logic rd, input logic clr, input int lvl,
                     input logic [7:0] rdat, input logic ov);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wd = wd; v.rd = rd; v.clr = clr;
    v.lvl = lvl; v.rv = (lvl > 0); v.rdat = rdat; v.ov = ov;
    v.full = (lvl == 16); v.thr = (lvl >= 8);
    tbl.push_back(v);
  endtask

  initial begin
    int idx;
    int wp, rp;

    // ---------------- directed table ----------------
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0);   // reset
    add(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1, 8'h11, 1'b0);
    add(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 2, 8'h11, 1'b0);
    add(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 3, 8'h11, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 8'h22, 1'b0);   // drain in order
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h33, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0);   // ready while empty
    for (int k = 0; k < 16; k++)
      add(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, k + 1, 8'h00, 1'b0);
    add(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 16, 8'h00, 1'b1);  // dropped
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16, 8'h00, 1'b0);  // clear
    add(1'b0, 1'b1, 8'hBB, 1'b1, 1'b0, 16, 8'h01, 1'b0);  // write-through-full
    for (int j = 1; j <= 16; j++)
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16 - j,
          (j <= 14) ? 8'(j + 1) : ((j == 15) ? 8'hBB : 8'h00), 1'b0);
    for (int k = 0; k < 8; k++)                            // threshold
      add(1'b0, 1'b1, 8'(8'h40 + k), 1'b0, 1'b0, k + 1, 8'h40, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 7, 8'h41, 1'b0);
    for (int i = 0; i < 40; i++)                           // pointer wrap
      add(1'b0, 1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 7,
          (i + 1 < 7) ? 8'(8'h41 + i + 1) : 8'(8'h60 + i + 1 - 7), 1'b0);
    for (int k = 0; k < 9; k++)
      add(1'b0, 1'b1, 8'(8'h90 + k), 1'b0, 1'b0, 8 + k, 8'h81, 1'b0);
    add(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 16, 8'h81, 1'b1);  // drop
    add(1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 16, 8'h81, 1'b1);  // drop + clear
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16, 8'h81, 1'b0);  // clear alone
    for (int j = 1; j <= 11; j++)
      add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16 - j,
          (j < 7) ? 8'(8'h81 + j) : 8'(8'h90 + j - 7), 1'b0);
    add(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 0, 8'h00, 1'b0);   // reset with 5 stored
    add(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1, 8'h5A, 1'b0);

    idx = 0;
    foreach (tbl[n]) begin
      step(tbl[n].rst, tbl[n].wv, tbl[n].wd, tbl[n].rd, tbl[n].clr);
      chk($sformatf("tbl%0d_level", n), 32'(o_level), 32'(tbl[n].lvl));
      chk($sformatf("tbl%0d_valid", n), 32'(o_rd_valid), 32'(tbl[n].rv));
      chk($sformatf("tbl%0d_data", n), 32'(o_rd_data), 32'(tbl[n].rdat));
      chk($sformatf("tbl%0d_empty", n), 32'(o_empty), 32'(tbl[n].lvl == 0));
      chk($sformatf("tbl%0d_full", n), 32'(o_full), 32'(tbl[n].full));
      chk($sformatf("tbl%0d_thresh", n), 32'(o_thresh), 32'(tbl[n].thr));
      chk($sformatf("tbl%0d_ovr", n), 32'(o_overrun), 32'(tbl[n].ov));
      idx++;
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    // Hand sequence: fill, drop three, clear with a drop -> 1, clear -> 0.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'hCC, 1'b0, 1'b0);
    chk("dropcnt_three", 32'(o_drop_count), 32'd3);
    step(1'b0, 1'b1, 8'hCD, 1'b0, 1'b1);
    chk("dropcnt_drop_clr", 32'(o_drop_count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("dropcnt_clr", 32'(o_drop_count), 32'd0);
    for (int k = 0; k < 260; k++) step(1'b0, 1'b1, 8'hCE, 1'b0, 1'b0);
    chk("dropcnt_sat", 32'(o_drop_count), 32'd255);
`endif

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 1600; n++) begin
      case ((n / 200) % 4)
        0:       begin wp = 80; rp = 20; end  // filling, overruns
        1:       begin wp = 20; rp = 80; end  // draining
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 60; end
      endcase
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 99) < wp),
           8'($urandom),
           ($urandom_range(0, 99) < rp),
           ($urandom_range(0, 31) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
